// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC, instruction fetch handshake, IR latch and condition check
// Optional condition execution enabled by `FETCH_COND_EXEC_EN (otherwise every cond passes).
module inst_fetch_unit #(
    parameter int ADDR_W   = 6,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              Write_IR,
    input  logic              Write_PC,
    input  logic [3:0]        NZCV,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] Inst_Addr,
    output logic [3:0]        cond,
    output logic [27:0]       IR,
    output logic              ir_valid,
    output logic              flag,
    output logic              fetch_busy,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE   = 1;
    localparam logic [3:0]        WAIT_END = 4'(MAX_WAIT - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        cond_q;
    logic [27:0]       ir_q;
    logic              ir_valid_q;
    logic [3:0]        wait_cnt;
    logic              inc_pending;
    logic              write_ir_q;
    logic              fetch_err_q;

    logic              pass;
    logic              start;
    logic              skip;
    logic              capture;
    logic              timeout;
    logic              consume;

`ifdef FETCH_COND_EXEC_EN
    logic n, z, c, v;
    assign {n, z, c, v} = NZCV;

    always_comb begin
        pass = 1'b0;
        case (cond_q)
            4'h0: pass = z;
            4'h1: pass = !z;
            4'h2: pass = c;
            4'h3: pass = !c;
            4'h4: pass = n;
            4'h5: pass = !n;
            4'h6: pass = v;
            4'h7: pass = !v;
            4'h8: pass = c && !z;
            4'h9: pass = !c || z;
            4'hA: pass = (n == v);
            4'hB: pass = (n != v);
            4'hC: pass = !z && (n == v);
            4'hD: pass = z || (n != v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
`else
    logic unused_nzcv;
    assign unused_nzcv = ^NZCV;
    assign pass = 1'b1;
`endif

    // Falling edge of Write_IR means the controller has consumed the word.
    assign consume = !Write_IR && write_ir_q;

    always_comb begin
        state_n = state;
        start   = 1'b0;
        skip    = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (Write_IR) begin
                    if (!ir_valid_q) begin
                        start   = 1'b1;
                        state_n = S_REQ;
                    end else if (!pass) begin
                        // Failed-condition word: drop it and move on to the next address.
                        start   = 1'b1;
                        skip    = 1'b1;
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    capture = 1'b1;
                    state_n = S_IDLE;
                end else if (wait_cnt == WAIT_END) begin
                    timeout = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            cond_q      <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            wait_cnt    <= '0;
            inc_pending <= 1'b0;
            write_ir_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            write_ir_q  <= Write_IR;
            fetch_err_q <= timeout;
            if (start) begin
                inc_pending <= Write_PC;
            end
            if (state == S_REQ) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !mem_ack && !timeout) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (skip || (capture && inc_pending)) begin
                pc <= pc + PC_ONE;
            end
            if (capture) begin
                {cond_q, ir_q} <= mem_rdata;
                ir_valid_q     <= 1'b1;
            end else if (skip || consume) begin
                ir_valid_q <= 1'b0;
            end
        end
    end

    assign fetch_busy = (state != S_IDLE);
    assign mem_req    = fetch_busy;
    assign mem_addr   = pc;
    assign Inst_Addr  = pc;
    assign cond       = cond_q;
    assign IR         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign flag       = ir_valid_q && pass;
    assign fetch_err  = fetch_err_q;

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage directly upstream of the data-processing CPU controller. Holds the PC and issues word fetches to the instruction memory over a req/ack handshake. Latches the returned word into the cond/IR registers and evaluates the 4-bit condition field against the current NZCV. Produces `flag`, which tells the controller to leave its fetch state and execute.

## Interface
Parameters:
- ADDR_W, 6: PC / instruction address width (words).
- MAX_WAIT, 15: cycles to wait for `mem_ack` before aborting a fetch (4-bit counter, 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Write_IR  in  1  fetch request from controller; level, sampled each cycle.
- Write_PC  in  1  increment PC when the pending fetch completes.
- NZCV  in  4  flags: [3]N [2]Z [1]C [0]V.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  word address of request (= PC).
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  instruction word.
- Inst_Addr  out  ADDR_W  current PC.
- cond  out  4  latched instruction [31:28].
- IR  out  28  latched instruction [27:0].
- ir_valid  out  1  cond/IR hold a completed fetch.
- flag  out  1  ir_valid AND condition passes.
- fetch_busy  out  1  fetch in progress (state REQ or WAIT).
- fetch_err  out  1  one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ when Write_IR=1 and ir_valid=0. A set ir_valid with Write_IR=1 means the controller is stalled on flag=0. Hold the word, no refetch.
- Exception: if ir_valid=1 and flag=0, the instruction is skipped. Next Write_IR cycle clears ir_valid, increments PC and goes to REQ. Failed-condition instructions advance without controller involvement.
- IR consumption: on Write_IR falling edge (Write_IR=0 after 1), ir_valid clears. The next Write_IR fetches afresh.
- REQ: mem_req=1, mem_addr=PC, wait counter loaded 0; next state WAIT.
- WAIT: mem_req held 1. On mem_ack, do all of the following:
  - {cond,IR} <= mem_rdata; ir_valid <= 1.
  - PC <= PC+1 if Write_PC sampled 1 at REQ entry.
  - Go to IDLE.
- WAIT timeout: counter increments each cycle without ack. At MAX_WAIT: fetch_err pulse, ir_valid stays 0, PC unchanged, go to IDLE.
- PC arithmetic: modulo 2^ADDR_W; PC = 2^ADDR_W-1 increments to 0.
- mem_ack outside WAIT is ignored.
- Condition (cond -> pass):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0.
- flag is combinational from registered cond/ir_valid and live NZCV.

## Timing
- Reset values:
  - PC=0, cond=0, IR=0, ir_valid=0, state IDLE.
  - mem_req=0, mem_addr=0, fetch_busy=0, fetch_err=0.
  - flag=0 (ir_valid=0).
- Minimum fetch latency: Write_IR rises at edge n.
  - REQ at n+1; mem_ack may arrive n+2.
  - ir_valid/IR valid after edge n+3.
- fetch_busy is high exactly in REQ/WAIT.
- Rst mid-fetch: immediate return to reset values; late ack is ignored (state IDLE).
- Simultaneous ack and timeout terminal count: ack wins, no fetch_err.
- NZCV changing while ir_valid=1: flag follows combinationally the same cycle.

## Configuration
- `FETCH_COND_EXEC_EN`
- Defined: full condition table above.
- Undefined: condition logic removed; pass=1 for every cond value including F, so flag = ir_valid. Skip path never taken.

## Test plan
- Reset then Write_IR=Write_PC=1, memory ack 1 cycle after req, word 0xE0812003 at addr 0 -> cond=E, IR=0x0812003, flag=1 at n+3, Inst_Addr=1.
- Word 0x00000000 (EQ) with NZCV=0000 -> flag=0; next Write_IR fetches addr 1 automatically, PC=2 after ack. With NZCV=0100 -> flag=1.
- PC at 63, fetch with Write_PC=1 -> Inst_Addr wraps to 0, mem_addr was 63.
- No ack for 15 cycles -> fetch_err one-cycle pulse, ir_valid=0, PC unchanged, fetch_busy falls.
- Rst asserted during WAIT, ack given next cycle -> all outputs at reset values, IR stays 0.
- Exhaustive: all 16 cond values × 16 NZCV values versus the table. With `FETCH_COND_EXEC_EN` undefined, flag=1 for all 256 cases.
